// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between CPU writeback and a
// queue of GPU register writes. A starvation counter forces a GPU grant past STARVE_LIMIT.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int REG_NUM      = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int RW = $clog2(REG_NUM),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_w_en,
    input  logic [RW-1:0]         cpu_w_rd,
    input  logic [ADDR_WIDTH-1:0] cpu_w_result,
    input  logic                  gpu_req_valid,
    output logic                  gpu_req_ready,
    input  logic [RW-1:0]         gpu_req_rd,
    input  logic [ADDR_WIDTH-1:0] gpu_req_data,
    output logic                  cpu_stall,
    output logic                  w_en,
    output logic [RW-1:0]         w_rd,
    output logic [ADDR_WIDTH-1:0] w_result,
    output logic                  w_src,
    output logic [CW-1:0]         fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [RW-1:0]         entry_rd   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] entry_data [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [SW-1:0] starve_reg, starve_next;

    logic                  queue_nonempty;
    logic                  force_grant;
    logic                  gpu_grant;
    logic                  cpu_grant;
    logic                  push;
    logic                  pop;
    logic [RW-1:0]         head_rd;
    logic [ADDR_WIDTH-1:0] head_data;

    assign queue_nonempty = (count_reg != '0);
    assign force_grant    = (starve_reg == LIMIT_C) && queue_nonempty;

    // Ready comes only from the registered count, so a pop never frees a slot in the same cycle.
    assign gpu_req_ready = reset && (count_reg < DEPTH_C);
    assign push          = gpu_req_valid && gpu_req_ready;

    assign gpu_grant = force_grant || (!cpu_w_en && queue_nonempty);
    assign cpu_grant = !force_grant && cpu_w_en;
    assign pop       = gpu_grant;

    assign head_rd   = entry_rd[rd_ptr_reg];
    assign head_data = entry_data[rd_ptr_reg];

    assign cpu_stall  = force_grant;
    assign fifo_count = count_reg;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (gpu_grant || (count_next == '0)) begin
            starve_next = '0;
        end else if (cpu_grant && queue_nonempty && (starve_reg != LIMIT_C)) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    // Queue storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_rd[wr_ptr_reg]   <= gpu_req_rd;
            entry_data[wr_ptr_reg] <= gpu_req_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
        end
    end

    // Writes to x0 still update w_rd/w_result/w_src but never raise w_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_en     <= 1'b0;
            w_rd     <= '0;
            w_result <= '0;
            w_src    <= 1'b0;
        end else if (gpu_grant) begin
            w_en     <= (head_rd != '0);
            w_rd     <= head_rd;
            w_result <= head_data;
            w_src    <= 1'b1;
        end else if (cpu_grant) begin
            w_en     <= (cpu_w_rd != '0);
            w_rd     <= cpu_w_rd;
            w_result <= cpu_w_result;
            w_src    <= 1'b0;
        end else begin
            w_en     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        cpu_w_en;
    logic [4:0]  cpu_w_rd;
    logic [63:0] cpu_w_result;
    logic        gpu_req_valid;
    logic        gpu_req_ready;
    logic [4:0]  gpu_req_rd;
    logic [63:0] gpu_req_data;
    logic        cpu_stall;
    logic        w_en;
    logic [4:0]  w_rd;
    logic [63:0] w_result;
    logic        w_src;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(
        .ADDR_WIDTH(64), .REG_NUM(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_w_en(cpu_w_en), .cpu_w_rd(cpu_w_rd), .cpu_w_result(cpu_w_result),
        .gpu_req_valid(gpu_req_valid), .gpu_req_ready(gpu_req_ready),
        .gpu_req_rd(gpu_req_rd), .gpu_req_data(gpu_req_data),
        .cpu_stall(cpu_stall),
        .w_en(w_en), .w_rd(w_rd), .w_result(w_result), .w_src(w_src),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, required %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a queue of pending GPU writes plus a count of CPU-only grants.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } req_t;

    req_t        mq[$];
    int          m_starve;
    logic        m_w_en;
    logic [4:0]  m_w_rd;
    logic [63:0] m_w_res;
    logic        m_w_src;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_w_en   = 1'b0;
        m_w_rd   = '0;
        m_w_res  = '0;
        m_w_src  = 1'b0;
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance, check write port.
    task automatic step(input logic ce, input logic [4:0] crd, input logic [63:0] cdat,
                        input logic gv, input logic [4:0] grd, input logic [63:0] gdat);
        bit   rdy, frc, take_gpu, take_cpu, had_entries;
        req_t e;
        cpu_w_en      = ce;
        cpu_w_rd      = crd;
        cpu_w_result  = cdat;
        gpu_req_valid = gv;
        gpu_req_rd    = grd;
        gpu_req_data  = gdat;
        #1;
        had_entries = (mq.size() != 0);
        rdy = (mq.size() < DEPTH);
        frc = (m_starve == LIMIT) && had_entries;
        chk("ready", gpu_req_ready, rdy);
        chk("stall", cpu_stall, frc);
        chk("count", fifo_count, mq.size());
        take_gpu = frc || (!ce && had_entries);
        take_cpu = !frc && ce;
        if (take_gpu) begin
            e = mq.pop_front();
            m_w_en  = (e.rd != 0);
            m_w_rd  = e.rd;
            m_w_res = e.data;
            m_w_src = 1'b1;
        end else if (take_cpu) begin
            m_w_en  = (crd != 0);
            m_w_rd  = crd;
            m_w_res = cdat;
            m_w_src = 1'b0;
        end else begin
            m_w_en = 1'b0;
        end
        if (gv && rdy) mq.push_back('{rd: grd, data: gdat});
        if (take_gpu || mq.size() == 0) m_starve = 0;
        else if (take_cpu && had_entries && m_starve < LIMIT) m_starve++;
        @(posedge clk);
        #1;
        chk("w_en", w_en, m_w_en);
        chk("w_rd", w_rd, m_w_rd);
        chk("w_result", w_result, m_w_res);
        chk("w_src", w_src, m_w_src);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    typedef struct {
        logic        ce;
        logic [4:0]  crd;
        logic [63:0] cdat;
        logic        gv;
        logic [4:0]  grd;
        logic [63:0] gdat;
        logic        e_ready;
        logic        e_stall;
        logic [2:0]  e_count;
        logic        e_wen;
        logic [4:0]  e_wrd;
        logic [63:0] e_wres;
        logic        e_wsrc;
    } vec_t;

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        // ce crd cdat | gv grd gdat | ready stall count | wen wrd wres wsrc
        vt[0]  = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 0, 0, 0,  64'h0,    0};
        vt[1]  = '{1, 5, 64'hDEAD, 0, 0,  64'h0,    1, 0, 0, 1, 5,  64'hDEAD, 0};
        vt[2]  = '{0, 0, 64'h0,    1, 7,  64'h1234, 1, 0, 0, 0, 5,  64'hDEAD, 0};
        vt[3]  = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 1, 1, 7,  64'h1234, 1};
        vt[4]  = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 0, 0, 7,  64'h1234, 1};
        vt[5]  = '{1, 1, 64'h11,   1, 10, 64'hA0,   1, 0, 0, 1, 1,  64'h11,   0};
        vt[6]  = '{1, 2, 64'h22,   1, 11, 64'hA1,   1, 0, 1, 1, 2,  64'h22,   0};
        vt[7]  = '{1, 3, 64'h33,   1, 12, 64'hA2,   1, 0, 2, 1, 3,  64'h33,   0};
        vt[8]  = '{1, 4, 64'h44,   1, 13, 64'hA3,   1, 0, 3, 1, 4,  64'h44,   0};
        vt[9]  = '{1, 5, 64'h55,   1, 14, 64'hA4,   0, 0, 4, 1, 5,  64'h55,   0};
        vt[10] = '{0, 0, 64'h0,    1, 14, 64'hA4,   0, 0, 4, 1, 10, 64'hA0,   1};
        vt[11] = '{0, 0, 64'h0,    1, 14, 64'hA4,   1, 0, 3, 1, 11, 64'hA1,   1};
        vt[12] = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 3, 1, 12, 64'hA2,   1};
        vt[13] = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 2, 1, 13, 64'hA3,   1};
        vt[14] = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 1, 1, 14, 64'hA4,   1};
        vt[15] = '{0, 0, 64'h0,    0, 0,  64'h0,    1, 0, 0, 0, 14, 64'hA4,   1};

        reset         = 1'b0;
        cpu_w_en      = 1'b0;
        cpu_w_rd      = '0;
        cpu_w_result  = '0;
        gpu_req_valid = 1'b0;
        gpu_req_rd    = '0;
        gpu_req_data  = '0;
        model_reset();

        // Reset held for 3 cycles: everything at zero, including ready.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_w_en", w_en, 0);
            chk("rst_w_rd", w_rd, 0);
            chk("rst_w_result", w_result, 0);
            chk("rst_w_src", w_src, 0);
            chk("rst_stall", cpu_stall, 0);
            chk("rst_ready", gpu_req_ready, 0);
            chk("rst_count", fifo_count, 0);
        end
        reset = 1'b1;
        #1;
        chk("rel_ready", gpu_req_ready, 1);
        chk("rel_count", fifo_count, 0);

        // Directed table: CPU write, GPU in idle gap, full queue with no pop-to-push bypass.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("vec%0d_ready", i), gpu_req_ready, vt[i].e_ready);
            chk($sformatf("vec%0d_stall", i), cpu_stall, vt[i].e_stall);
            chk($sformatf("vec%0d_count", i), fifo_count, vt[i].e_count);
            step(vt[i].ce, vt[i].crd, vt[i].cdat, vt[i].gv, vt[i].grd, vt[i].gdat);
            chk($sformatf("vec%0d_w_en", i), w_en, vt[i].e_wen);
            chk($sformatf("vec%0d_w_rd", i), w_rd, vt[i].e_wrd);
            chk($sformatf("vec%0d_w_result", i), w_result, vt[i].e_wres);
            chk($sformatf("vec%0d_w_src", i), w_src, vt[i].e_wsrc);
        end

        // Starvation: one queued entry, CPU busy every cycle; 8 CPU grants, then a forced GPU grant.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'hBEEF);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve%0d_stall", i), cpu_stall, (i == LIMIT));
            step(1'b1, 5'd9, 64'hC0DE, 1'b0, 5'd0, 64'd0);
            if (i < LIMIT || i == LIMIT + 1) begin
                chk($sformatf("starve%0d_src", i), w_src, 0);
                chk($sformatf("starve%0d_rd", i), w_rd, 9);
                chk($sformatf("starve%0d_en", i), w_en, 1);
            end else begin
                chk($sformatf("starve%0d_src", i), w_src, 1);
                chk($sformatf("starve%0d_rd", i), w_rd, 20);
                chk($sformatf("starve%0d_data", i), w_result, 64'hBEEF);
            end
        end

        // x0 GPU write is popped without a write enable.
        idle();
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h99);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("x0_w_en", w_en, 0);
        chk("x0_w_src", w_src, 1);
        chk("x0_count", fifo_count, 0);

        // Reset asserted with 3 entries queued.
        step(1'b1, 5'd3, 64'h1, 1'b1, 5'd21, 64'h21);
        step(1'b1, 5'd3, 64'h2, 1'b1, 5'd22, 64'h22);
        step(1'b1, 5'd3, 64'h3, 1'b1, 5'd23, 64'h23);
        chk("midq_count", fifo_count, 3);
        cpu_w_en      = 1'b0;
        gpu_req_valid = 1'b0;
        reset         = 1'b0;
        #1;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_ready", gpu_req_ready, 0);
        chk("midrst_w_en", w_en, 0);
        chk("midrst_w_rd", w_rd, 0);
        chk("midrst_stall", cpu_stall, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk($sformatf("post_rst%0d_w_en", i), w_en, 0);
        end

        // Randomized traffic with CPU-heavy bias so forced grants and full queues occur.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 80), 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                 ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
